rf_wb_arbiter: RTL and testbench

Write-port arbiter for the three-ported register file. It shares the file's single write port between the in-order pipeline writeback (primary) and the long-latency execution unit (secondary: divider/load miss path), buffering secondary results in a small FIFO. It tracks registers with outstanding secondary writes so the issue logic can stall on hazards. It sits between the WB stage and the register file's write port, and drives the PC that accompanies each write for the trace output.

---
 rtl/rf_wb_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file's single write port between the
// in-order writeback stage (primary, never back-pressured) and the
// long-latency execution unit (secondary), which is buffered in a small FIFO.
//
// Ports:
//   clk, reset                      clock; asynchronous active-high reset
//   pri_valid/addr/data/pc          primary write request (x0 ignored)
//   sec_valid/ready/addr/data/pc    secondary result handshake into the FIFO
//   sb_set_valid/addr               issue of a secondary-unit op (pending bit)
//   chk_addr1/2 -> chk_busy1/2      source hazard lookup for the issue stage
//   stall_req                       head starved too long; pipeline must idle
//   rf_we/waddr/wdata/pc            register file write port plus trace PC
//
// Configuration macro: RF_WB_SCOREBOARD_EN
//   defined   - pending bitmap built; chk_busy* follow it.
//   undefined - no bitmap, chk_busy* tied 0; a primary write to index X
//               squashes queued entries for X (the primary is younger).
module rf_wb_arbiter #(
  parameter int REG_IDX_WIDTH = 5,
  parameter int WORD_LEN      = 32,
  parameter int ADDR_SIZE     = 32,
  parameter int FIFO_DEPTH    = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pri_valid,
  input  logic [REG_IDX_WIDTH-1:0] pri_addr,
  input  logic [WORD_LEN-1:0]      pri_data,
  input  logic [ADDR_SIZE-1:0]     pri_pc,
  input  logic                     sec_valid,
  output logic                     sec_ready,
  input  logic [REG_IDX_WIDTH-1:0] sec_addr,
  input  logic [WORD_LEN-1:0]      sec_data,
  input  logic [ADDR_SIZE-1:0]     sec_pc,
  input  logic                     sb_set_valid,
  input  logic [REG_IDX_WIDTH-1:0] sb_set_addr,
  input  logic [REG_IDX_WIDTH-1:0] chk_addr1,
  input  logic [REG_IDX_WIDTH-1:0] chk_addr2,
  output logic                     chk_busy1,
  output logic                     chk_busy2,
  output logic                     stall_req,
  output logic                     rf_we,
  output logic [REG_IDX_WIDTH-1:0] rf_waddr,
  output logic [WORD_LEN-1:0]      rf_wdata,
  output logic [ADDR_SIZE-1:0]     rf_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage: payload carries no reset, occupancy lives in count/pointers.
  logic [REG_IDX_WIDTH-1:0] ent_addr_q [FIFO_DEPTH];
  logic [WORD_LEN-1:0]      ent_data_q [FIFO_DEPTH];
  logic [ADDR_SIZE-1:0]     ent_pc_q   [FIFO_DEPTH];
  // Per-entry live bit; a squashed entry still pops but without rf_we.
  logic [FIFO_DEPTH-1:0]    ent_vld_q, ent_vld_d;
  logic [FIFO_DEPTH-1:0]    squash;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       count_blk_q, count_blk_d;
  logic             stall_q, stall_d;

  logic pri_eff;
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;

  assign pri_eff    = pri_valid && (pri_addr != '0);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  // Ready depends only on registered occupancy: a full FIFO refuses input
  // even in a cycle where it drains.
  assign sec_ready  = !fifo_full;
  // x0 results complete the handshake but are dropped.
  assign push       = sec_valid && !fifo_full && (sec_addr != '0);
  assign pop        = !pri_eff && !fifo_empty;
  assign stall_req  = stall_q;

  // Write-port mux: effective primary first, else the FIFO head.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    rf_pc    = '0;
    if (pri_eff) begin
      rf_we    = 1'b1;
      rf_waddr = pri_addr;
      rf_wdata = pri_data;
      rf_pc    = pri_pc;
    end else if (!fifo_empty) begin
      rf_we    = ent_vld_q[rd_ptr_q];
      rf_waddr = ent_addr_q[rd_ptr_q];
      rf_wdata = ent_data_q[rd_ptr_q];
      rf_pc    = ent_pc_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_q[wr_ptr_q] <= sec_addr;
      ent_data_q[wr_ptr_q] <= sec_data;
      ent_pc_q[wr_ptr_q]   <= sec_pc;
    end
  end

  // Squash and live-bit update, one slice per entry. A freshly pushed slot is
  // never occupied, so push and squash cannot collide on the same entry.
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_ent
`ifdef RF_WB_SCOREBOARD_EN
      // Issue prevents WAW against queued entries; nothing to squash.
      assign squash[gi] = 1'b0;
`else
      assign squash[gi] = pri_eff && (ent_addr_q[gi] == pri_addr);
`endif
      assign ent_vld_d[gi] = (push && (wr_ptr_q == PTR_W'(gi))) ? 1'b1 :
                             squash[gi] ? 1'b0 : ent_vld_q[gi];
    end
  endgenerate

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Starvation: count cycles the head loses to an effective primary.
  always_comb begin
    count_blk_d = count_blk_q;
    if (pop || fifo_empty) begin
      count_blk_d = 4'd0;
    end else if (pri_eff && (count_blk_q != 4'hF)) begin
      count_blk_d = count_blk_q + 4'd1;
    end
    // Registered from the next count so stall rises the cycle after the
    // limit is reached and drops the cycle after the draining pop.
    stall_d = (count_blk_d >= 4'(STARVE_LIMIT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ent_vld_q   <= '0;
      count_blk_q <= 4'd0;
      stall_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ent_vld_q   <= ent_vld_d;
      count_blk_q <= count_blk_d;
      stall_q     <= stall_d;
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  localparam int NREGS = 1 << REG_IDX_WIDTH;
  logic [NREGS-1:0] pend_q, pend_d;

  // Clear on the head's pop, then set; same-index set wins.
  always_comb begin
    pend_d = pend_q;
    if (pop) begin
      pend_d[ent_addr_q[rd_ptr_q]] = 1'b0;
    end
    if (sb_set_valid && (sb_set_addr != '0)) begin
      pend_d[sb_set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign chk_busy1 = pend_q[chk_addr1];
  assign chk_busy2 = pend_q[chk_addr2];
`else
  logic unused_sb;
  assign unused_sb = ^{sb_set_valid, sb_set_addr, chk_addr1, chk_addr2};
  assign chk_busy1 = 1'b0;
  assign chk_busy2 = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: table-driven vectors with a queue-based model of
// the secondary FIFO, plus hand sequences for reset, starvation and hazards.
module tb_rf_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int PW = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pri_valid = 1'b0;
  logic [AW-1:0] pri_addr = '0;
  logic [DW-1:0] pri_data = '0;
  logic [PW-1:0] pri_pc = '0;
  logic sec_valid = 1'b0;
  logic sec_ready;
  logic [AW-1:0] sec_addr = '0;
  logic [DW-1:0] sec_data = '0;
  logic [PW-1:0] sec_pc = '0;
  logic sb_set_valid = 1'b0;
  logic [AW-1:0] sb_set_addr = '0;
  logic [AW-1:0] chk_addr1 = '0;
  logic [AW-1:0] chk_addr2 = '0;
  logic chk_busy1, chk_busy2, stall_req, rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [PW-1:0] rf_pc;

  rf_wb_arbiter #(
    .REG_IDX_WIDTH(AW), .WORD_LEN(DW), .ADDR_SIZE(PW),
    .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .pri_valid(pri_valid), .pri_addr(pri_addr), .pri_data(pri_data), .pri_pc(pri_pc),
    .sec_valid(sec_valid), .sec_ready(sec_ready), .sec_addr(sec_addr),
    .sec_data(sec_data), .sec_pc(sec_pc),
    .sb_set_valid(sb_set_valid), .sb_set_addr(sb_set_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2), .stall_req(stall_req),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_pc(rf_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pv; logic [AW-1:0] pa; logic [DW-1:0] pd;
    bit sv; logic [AW-1:0] sa; logic [DW-1:0] sd;
    bit sbv; logic [AW-1:0] sba; logic [AW-1:0] c1; logic [AW-1:0] c2;
    bit tbl; bit t_we; logic [AW-1:0] t_wa; bit t_rdy;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr; logic [DW-1:0] data; logic [PW-1:0] pc; bit vld;
  } ent_t;

  ent_t mq[$];
  int blk_m = 0;
  bit stall_m = 1'b0;
  bit pend_m[32];
  int n_checks = 0;
  int n_pass = 0;
  int n_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input bit pv, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                              input bit sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                              input bit t_we, input logic [AW-1:0] t_wa, input bit t_rdy);
    vec_t v;
    v = '{pv, pa, pd, sv, sa, sd, 1'b0, '0, '0, '0, 1'b1, t_we, t_wa, t_rdy};
    return v;
  endfunction

  function automatic vec_t hs(input bit pv, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                              input bit sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                              input bit sbv, input logic [AW-1:0] sba,
                              input logic [AW-1:0] c1, input logic [AW-1:0] c2);
    vec_t v;
    v = '{pv, pa, pd, sv, sa, sd, sbv, sba, c1, c2, 1'b0, 1'b0, '0, 1'b0};
    return v;
  endfunction

  // One clock cycle: drive, check against the model, advance the model.
  task automatic cyc(input vec_t v);
    bit pe, e_we, e_rdy, e_b1, e_b2, was_empty, popped;
    logic [AW-1:0] e_wa, pop_addr;
    logic [DW-1:0] e_wd;
    logic [PW-1:0] e_wp;
    pri_valid = v.pv; pri_addr = v.pa; pri_data = v.pd; pri_pc = v.pd + 32'h100;
    sec_valid = v.sv; sec_addr = v.sa; sec_data = v.sd; sec_pc = ~v.sd;
    sb_set_valid = v.sbv; sb_set_addr = v.sba;
    chk_addr1 = v.c1; chk_addr2 = v.c2;
    #1;
    pe = v.pv && (v.pa != 0);
    e_rdy = (mq.size() < DEPTH);
    e_we = 1'b0; e_wa = '0; e_wd = '0; e_wp = '0; pop_addr = '0;
    if (pe) begin
      e_we = 1'b1; e_wa = v.pa; e_wd = v.pd; e_wp = v.pd + 32'h100;
    end else if (mq.size() > 0) begin
      e_we = mq[0].vld; e_wa = mq[0].addr; e_wd = mq[0].data; e_wp = mq[0].pc;
    end
`ifdef RF_WB_SCOREBOARD_EN
    e_b1 = pend_m[v.c1]; e_b2 = pend_m[v.c2];
`else
    e_b1 = 1'b0; e_b2 = 1'b0;
`endif
    $display("cyc %0d: pri=%0b x%0d sec=%0b x%0d -> we=%0b x%0d data=%h rdy=%0b stall=%0b",
             n_cyc, v.pv, v.pa, v.sv, v.sa, rf_we, rf_waddr, rf_wdata, sec_ready, stall_req);
    n_cyc++;
    check("rf_we", rf_we, e_we);
    if (e_we) begin
      check("rf_waddr", rf_waddr, e_wa);
      check("rf_wdata", rf_wdata, e_wd);
      check("rf_pc", rf_pc, e_wp);
    end
    check("sec_ready", sec_ready, e_rdy);
    check("stall_req", stall_req, stall_m);
    check("chk_busy1", chk_busy1, e_b1);
    check("chk_busy2", chk_busy2, e_b2);
    if (v.tbl) begin
      check("tbl_we", rf_we, v.t_we);
      if (v.t_we) check("tbl_waddr", rf_waddr, v.t_wa);
      check("tbl_ready", sec_ready, v.t_rdy);
    end
    // Model update for the coming edge.
    was_empty = (mq.size() == 0);
    popped = 1'b0;
`ifndef RF_WB_SCOREBOARD_EN
    if (pe) foreach (mq[i]) if (mq[i].addr == v.pa) mq[i].vld = 1'b0;
`endif
    if (!pe && mq.size() > 0) begin
      popped = 1'b1; pop_addr = mq[0].addr;
      void'(mq.pop_front());
    end
    if (v.sv && e_rdy && v.sa != 0) mq.push_back('{v.sa, v.sd, ~v.sd, 1'b1});
    if (popped || was_empty) blk_m = 0;
    else if (pe && blk_m < 15) blk_m++;
    stall_m = (blk_m >= LIMIT);
    if (popped) pend_m[pop_addr] = 1'b0;
    if (v.sbv && v.sba != 0) pend_m[v.sba] = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    mq.delete();
    blk_m = 0; stall_m = 1'b0;
    foreach (pend_m[i]) pend_m[i] = 1'b0;
  endtask

  vec_t idle;
  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle = hs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0] = mk(0, 0, 0,           1, 7, 32'hDEADBEEF, 0, 0, 1);
    tbl[1] = mk(0, 0, 0,           0, 0, 0,           1, 7, 1);
    tbl[2] = mk(1, 3, 32'h11,      1, 4, 32'h44,      1, 3, 1);
    tbl[3] = mk(1, 3, 32'h12,      1, 5, 32'h55,      1, 3, 1);
    tbl[4] = mk(1, 3, 32'h13,      1, 6, 32'h66,      1, 3, 0);
    tbl[5] = mk(0, 0, 0,           1, 6, 32'h66,      1, 4, 0);
    tbl[6] = mk(0, 0, 0,           1, 6, 32'h66,      1, 5, 1);
    tbl[7] = mk(1, 0, 32'h99,      1, 0, 32'h77,      1, 6, 1);
    tbl[8] = mk(0, 0, 0,           0, 0, 0,           0, 0, 1);
    model_reset();

    // Reset state.
    chk_addr1 = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", rf_we, 1'b0);
    check("rst_waddr", rf_waddr, '0);
    check("rst_wdata", rf_wdata, '0);
    check("rst_pc", rf_pc, '0);
    check("rst_ready", sec_ready, 1'b1);
    check("rst_stall", stall_req, 1'b0);
    check("rst_busy1", chk_busy1, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) cyc(tbl[i]);

    // Starvation: two queued entries held off by primary x3.
    cyc(hs(1, 3, 32'h21, 1, 10, 32'hA0A0, 0, 0, 0, 0));
    cyc(hs(1, 3, 32'h22, 1, 11, 32'hB0B0, 0, 0, 0, 0));
    cyc(hs(1, 3, 32'h23, 0, 0, 0, 0, 0, 0, 0));
    cyc(hs(1, 3, 32'h24, 0, 0, 0, 0, 0, 0, 0));
    check("starve_pre", stall_req, 1'b0);
    cyc(hs(1, 3, 32'h25, 0, 0, 0, 0, 0, 0, 0));
    check("starve_rise", stall_req, 1'b1);
    cyc(hs(1, 3, 32'h26, 0, 0, 0, 0, 0, 0, 0));
    cyc(idle);
    check("starve_drop", stall_req, 1'b0);
    cyc(idle);
    cyc(idle);

`ifdef RF_WB_SCOREBOARD_EN
    // Pending bit for x9 from issue until its pop edge.
    cyc(hs(0, 0, 0, 0, 0, 0, 1, 9, 0, 9));
    check("busy_set", chk_busy2, 1'b1);
    cyc(hs(1, 3, 32'h31, 1, 9, 32'h9999, 0, 0, 0, 9));
    cyc(hs(1, 3, 32'h32, 0, 0, 0, 0, 0, 0, 9));
    cyc(hs(0, 0, 0, 0, 0, 0, 0, 0, 0, 9));
    check("busy_clear", chk_busy2, 1'b0);
`else
    // Younger primary x9 squashes the queued x9 entry.
    cyc(hs(1, 3, 32'h31, 1, 9, 32'h9999, 0, 0, 0, 9));
    cyc(hs(1, 9, 32'h4242, 0, 0, 0, 0, 0, 0, 9));
    cyc(idle);
    check("squash_busy", chk_busy2, 1'b0);
    cyc(idle);
`endif

    // Reset mid-burst with two entries queued.
    cyc(hs(1, 3, 32'h51, 1, 5, 32'h5555, 1, 5, 5, 0));
    cyc(hs(1, 3, 32'h52, 1, 6, 32'h6666, 0, 0, 5, 0));
    pri_valid = 1'b0; sec_valid = 1'b0; sb_set_valid = 1'b0; chk_addr1 = 5'd5;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("midrst_we", rf_we, 1'b0);
    check("midrst_ready", sec_ready, 1'b1);
    check("midrst_busy1", chk_busy1, 1'b0);
    check("midrst_stall", stall_req, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(hs(0, 0, 0, 0, 0, 0, 0, 0, 5, 0));
    cyc(hs(0, 0, 0, 1, 12, 32'hC0DE, 0, 0, 5, 0));
    cyc(idle);
    cyc(idle);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
